// File: rtl/spi_pkg.sv
// Shared types and frame-width helper for the parametrised SPI subordinate.
// Optional feature macro: SPI_SUB_PARITY_EN (trailing even-parity bit on
// both request and response frames).
package spi_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_ACCESS,
        ST_TX,
        ST_DONE
    } state_e;

`ifdef SPI_SUB_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Serial frame length: {op, addr, data} plus an optional parity bit.
    function automatic int frame_w(input int addr_w, input int data_w, input bit parity);
        return OP_W + addr_w + data_w + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/spi_sub_shifter.sv
// Serial datapath of the SPI subordinate: request shift-in on posedge,
// response parallel load and shift on posedge, MISO driven on negedge,
// plus the shared bit counter. All sequencing comes from the FSM.
module spi_sub_shifter #(
    parameter int FRAME_W = 44,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mosi,
    input  logic               shift_in_en,
    input  logic               rx_clr,
    input  logic               tx_load,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_shift_en,
    input  logic               drive_en,
    input  logic               cnt_inc,
    input  logic               cnt_clr,
    output logic [FRAME_W-1:0] rx_next,
    output logic [CNT_W-1:0]   cnt,
    output logic               miso
);

    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               miso_q, miso_d;

    // Next-state of shift registers, counter and the MISO driver.
    always_comb begin
        rx_next = {rx_q[FRAME_W-2:0], mosi};
        rx_d    = rx_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        miso_d  = drive_en ? tx_q[FRAME_W-1] : 1'b0;
        if (rx_clr) begin
            rx_d = '0;
        end else if (shift_in_en) begin
            rx_d = rx_next;
        end
        if (tx_load) begin
            tx_d = tx_data;
        end else if (tx_shift_en) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Posedge state: sample MOSI, advance the response, count bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q  <= '0;
            tx_q  <= '0;
            cnt_q <= '0;
        end else begin
            rx_q  <= rx_d;
            tx_q  <= tx_d;
            cnt_q <= cnt_d;
        end
    end

    // MISO only changes on negedge so the main can sample it on posedge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= miso_d;
        end
    end

    assign cnt  = cnt_q;
    assign miso = miso_q;

endmodule

// File: rtl/spi_sub_param.sv
// Parametrised mode-0 SPI subordinate. Receives {op, addr, data} MSB first,
// performs one single-cycle memory read or write, then echoes
// {op, addr, data} back on MISO after one turnaround cycle.
// Optional feature macro: SPI_SUB_PARITY_EN.
module spi_sub_param
    import spi_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              r_en,
    output logic              w_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy,
    output logic              err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W, PARITY_EN);
    localparam int BODY_W  = OP_W + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    state_e              state_q, state_d;
    logic                r_en_q, r_en_d;
    logic                w_en_q, w_en_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_o_q, data_o_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                illegal_q, illegal_d;
    logic                par_fail_q, par_fail_d;

    logic                shift_in_en, rx_clr, tx_load, tx_shift_en, cnt_inc, cnt_clr;
    logic                drive_en;
    logic [FRAME_W-1:0]  rx_next, tx_data;
    logic [CNT_W-1:0]    cnt;

    logic [BODY_W-1:0]   rx_body, resp_body;
    logic [OP_W-1:0]     rx_op;
    logic [ADDR_W-1:0]   rx_addr;
    logic [DATA_W-1:0]   rx_data, resp_data;
    logic                par_ok;

    // Fields decoded from the request including the bit being sampled now,
    // so the memory-side registers are valid in the first ACCESS cycle.
    assign rx_body = rx_next[FRAME_W-1 -: BODY_W];
    assign rx_op   = rx_body[BODY_W-1 -: OP_W];
    assign rx_addr = rx_body[DATA_W +: ADDR_W];
    assign rx_data = rx_body[DATA_W-1:0];

    // Echoed data: all ones for an illegal op, zero on a parity failure,
    // memory read data for reads, the received data otherwise.
    always_comb begin
        resp_data = data_o_q;
        if (par_fail_q) begin
            resp_data = '0;
        end else if (illegal_q) begin
            resp_data = '1;
        end else if (op_q == OP_READ) begin
            resp_data = data_i;
        end
    end

    assign resp_body = {op_q, addr_q, resp_data};

`ifdef SPI_SUB_PARITY_EN
    assign par_ok  = ~^rx_next;
    assign tx_data = {resp_body, ^resp_body};
`else
    assign par_ok  = 1'b1;
    assign tx_data = resp_body;
`endif

    assign drive_en = (state_q == ST_TX);

    // FSM next-state, memory-side register and shifter control decode.
    always_comb begin
        state_d     = state_q;
        r_en_d      = r_en_q;
        w_en_d      = w_en_q;
        err_d       = err_q;
        busy_d      = busy_q;
        addr_d      = addr_q;
        data_o_d    = data_o_q;
        op_d        = op_q;
        illegal_d   = illegal_q;
        par_fail_d  = par_fail_q;
        shift_in_en = 1'b0;
        rx_clr      = 1'b0;
        tx_load     = 1'b0;
        tx_shift_en = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cs_n) begin
                    shift_in_en = 1'b1;
                    cnt_inc     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_RX;
                end
            end
            ST_RX: begin
                if (cs_n) begin
                    rx_clr  = 1'b1;
                    cnt_clr = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    shift_in_en = 1'b1;
                    cnt_inc     = 1'b1;
                    if (cnt == LAST_BIT) begin
                        op_d       = rx_op;
                        addr_d     = rx_addr;
                        data_o_d   = rx_data;
                        illegal_d  = rx_op[1];
                        par_fail_d = !par_ok;
                        err_d      = rx_op[1] | !par_ok;
                        r_en_d     = par_ok & (rx_op == OP_READ);
                        w_en_d     = par_ok & (rx_op == OP_WRITE);
                        state_d    = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // One cycle regardless of cs_n: the access always completes.
                r_en_d  = 1'b0;
                w_en_d  = 1'b0;
                err_d   = 1'b0;
                tx_load = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_TX;
            end
            ST_TX: begin
                if (cs_n) begin
                    cnt_clr = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tx_shift_en = 1'b1;
                    cnt_inc     = 1'b1;
                    if (cnt == LAST_BIT) begin
                        cnt_clr = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cs_n) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            r_en_q     <= 1'b0;
            w_en_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            data_o_q   <= '0;
            op_q       <= '0;
            illegal_q  <= 1'b0;
            par_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_en_q     <= r_en_d;
            w_en_q     <= w_en_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            data_o_q   <= data_o_d;
            op_q       <= op_d;
            illegal_q  <= illegal_d;
            par_fail_q <= par_fail_d;
        end
    end

    spi_sub_shifter #(
        .FRAME_W (FRAME_W),
        .CNT_W   (CNT_W)
    ) u_shifter (
        .clk         (sclk),
        .rst         (rst),
        .mosi        (mosi),
        .shift_in_en (shift_in_en),
        .rx_clr      (rx_clr),
        .tx_load     (tx_load),
        .tx_data     (tx_data),
        .tx_shift_en (tx_shift_en),
        .drive_en    (drive_en),
        .cnt_inc     (cnt_inc),
        .cnt_clr     (cnt_clr),
        .rx_next     (rx_next),
        .cnt         (cnt),
        .miso        (miso)
    );

    assign r_en   = r_en_q;
    assign w_en   = w_en_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign addr   = addr_q;
    assign data_o = data_o_q;

endmodule

// File: tb/tb_spi_sub_param.sv
// Bench for spi_sub_param: a default-size instance (A, 10/32) and a small
// instance (B, 6/16), each attached to a memory model. Vectors are applied
// as full SPI mode-0 frames; abort and reset corner cases are hand-written.
module tb_spi_sub_param;

`ifdef SPI_SUB_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FW_A = 2 + 10 + 32 + PAR;
    localparam int FW_B = 2 + 6 + 16 + PAR;

    // ---------------- clock / reset ----------------
    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    // ---------------- DUT A ----------------
    logic        cs_n_a = 1'b1, mosi_a = 1'b0;
    logic        miso_a, r_en_a, w_en_a, busy_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] data_o_a, data_i_a;
    logic [31:0] mem_a [0:1023];

    spi_sub_param #(.ADDR_W(10), .DATA_W(32)) dut_a (
        .sclk(sclk), .rst(rst), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a),
        .r_en(r_en_a), .w_en(w_en_a), .addr(addr_a), .data_o(data_o_a),
        .data_i(data_i_a), .busy(busy_a), .err(err_a)
    );

    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= 32'hC0DE0000 | i;
        end else if (w_en_a) begin
            mem_a[addr_a] <= data_o_a;
        end
    end
    assign data_i_a = mem_a[addr_a];

    // ---------------- DUT B ----------------
    logic        cs_n_b = 1'b1, mosi_b = 1'b0;
    logic        miso_b, r_en_b, w_en_b, busy_b, err_b;
    logic [5:0]  addr_b;
    logic [15:0] data_o_b, data_i_b;
    logic [15:0] mem_b [0:63];

    spi_sub_param #(.ADDR_W(6), .DATA_W(16)) dut_b (
        .sclk(sclk), .rst(rst), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b),
        .r_en(r_en_b), .w_en(w_en_b), .addr(addr_b), .data_o(data_o_b),
        .data_i(data_i_b), .busy(busy_b), .err(err_b)
    );

    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= 16'hB000 | 16'(i);
        end else if (w_en_b) begin
            mem_b[addr_b] <= data_o_b;
        end
    end
    assign data_i_b = mem_b[addr_b];

    // ---------------- enable monitor (mid-cycle sampling) ----------------
    int          w_cnt [2];
    int          r_cnt [2];
    int          e_cnt [2];
    logic [31:0] w_addr [2];
    logic [31:0] w_data [2];

    always @(negedge sclk) begin
        if (w_en_a) begin w_cnt[0]++; w_addr[0] = {22'd0, addr_a}; w_data[0] = data_o_a; end
        if (r_en_a) r_cnt[0]++;
        if (err_a)  e_cnt[0]++;
        if (w_en_b) begin w_cnt[1]++; w_addr[1] = {26'd0, addr_b}; w_data[1] = {16'd0, data_o_b}; end
        if (r_en_b) r_cnt[1]++;
        if (err_b)  e_cnt[1]++;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          sel;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] echo;
        logic        flip;
        logic        exp_w;
        logic        exp_r;
        logic        exp_e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk_vec(input int sel, input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] d, input logic [31:0] echo, input logic flip,
                                    input logic ew, input logic er, input logic ee);
        vec_t v;
        v.sel = sel; v.op = op; v.addr = a; v.data = d; v.echo = echo;
        v.flip = flip; v.exp_w = ew; v.exp_r = er; v.exp_e = ee;
        return v;
    endfunction

    // Serial frame {op, addr, data [, even parity]} right-aligned in 64 bits.
    function automatic logic [63:0] mk_frame(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] d, input int aw, input int dw);
        logic [63:0] v, am, dm;
        am = (64'd1 << aw) - 64'd1;
        dm = (64'd1 << dw) - 64'd1;
        v  = {62'd0, op};
        v  = (v << aw) | ({32'd0, a} & am);
        v  = (v << dw) | ({32'd0, d} & dm);
`ifdef SPI_SUB_PARITY_EN
        v  = (v << 1) | {63'd0, ^v};
`endif
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic c, input logic m);
        if (sel == 0) begin cs_n_a = c; mosi_a = m; end
        else          begin cs_n_b = c; mosi_b = m; end
    endtask

    function automatic logic get_miso(input int sel); return (sel == 0) ? miso_a : miso_b; endfunction
    function automatic logic get_busy(input int sel); return (sel == 0) ? busy_a : busy_b; endfunction
    function automatic logic get_act(input int sel);
        return (sel == 0) ? (w_en_a | r_en_a | err_a) : (w_en_b | r_en_b | err_b);
    endfunction

    // Full frame: request bits on negedges, one turnaround cycle, response
    // sampled on posedges, then cs_n high for one posedge.
    task automatic run_frame(input int sel, input string nm, input logic [63:0] req, input int fw,
                             output logic [63:0] resp, output logic act_n, output logic busy_mid);
        resp = '0;
        busy_mid = 1'b0;
        for (int i = 0; i < fw; i++) begin
            @(negedge sclk);
            drive(sel, 1'b0, req[fw-1-i]);
            if (i == 1) busy_mid = get_busy(sel);
        end
        @(posedge sclk); #1 act_n = get_act(sel);
        @(negedge sclk); drive(sel, 1'b0, 1'b0);
        @(posedge sclk);
        for (int j = 0; j < fw; j++) begin
            @(posedge sclk); #1 resp[fw-1-j] = get_miso(sel);
        end
        @(negedge sclk); #1;
        check({nm, "_miso_done"}, get_miso(sel), 1'b0);
        check({nm, "_busy_done"}, get_busy(sel), 1'b0);
        drive(sel, 1'b1, 1'b0);
        @(posedge sclk);
        @(negedge sclk);
    endtask

    task automatic do_vec(input string nm, input vec_t v);
        int aw, dw, fw;
        logic [63:0] req, resp, exp_resp;
        logic act_n, busy_mid;
        aw = (v.sel == 0) ? 10 : 6;
        dw = (v.sel == 0) ? 32 : 16;
        fw = (v.sel == 0) ? FW_A : FW_B;
        req      = mk_frame(v.op, v.addr, v.data, aw, dw) ^ {63'd0, v.flip};
        exp_resp = mk_frame(v.op, v.addr, v.echo, aw, dw);
        w_cnt[v.sel] = 0; r_cnt[v.sel] = 0; e_cnt[v.sel] = 0;
        run_frame(v.sel, nm, req, fw, resp, act_n, busy_mid);
        check({nm, "_resp"},     resp, exp_resp);
        check({nm, "_act_at_n"}, act_n, 1'b1);
        check({nm, "_busy_mid"}, busy_mid, 1'b1);
        check({nm, "_w_cnt"},    w_cnt[v.sel], v.exp_w);
        check({nm, "_r_cnt"},    r_cnt[v.sel], v.exp_r);
        check({nm, "_err_cnt"},  e_cnt[v.sel], v.exp_e);
        if (v.exp_w) begin
            check({nm, "_w_addr"}, w_addr[v.sel], v.addr);
            check({nm, "_w_data"}, w_data[v.sel], v.data);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] req;

        // Instance A: WRITE/READ corner addresses and data, illegal ops.
        tbl.push_back(mk_vec(0, 2'b01, 32'h3FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 0, 0));
        tbl.push_back(mk_vec(0, 2'b00, 32'h3FF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0, 1, 0));
        tbl.push_back(mk_vec(0, 2'b10, 32'h155, 32'h12345678, 32'hFFFFFFFF, 1'b0, 0, 0, 1));
        tbl.push_back(mk_vec(0, 2'b01, 32'h055, 32'h12345678, 32'h12345678, 1'b0, 1, 0, 0));
        tbl.push_back(mk_vec(0, 2'b00, 32'h055, 32'h0000DEAD, 32'h12345678, 1'b0, 0, 1, 0));
        tbl.push_back(mk_vec(0, 2'b11, 32'h000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0, 0, 1));
        tbl.push_back(mk_vec(0, 2'b00, 32'h200, 32'h00000000, 32'hC0DE0200, 1'b0, 0, 1, 0));
        tbl.push_back(mk_vec(0, 2'b01, 32'h000, 32'h00000001, 32'h00000001, 1'b0, 1, 0, 0));
        tbl.push_back(mk_vec(0, 2'b00, 32'h000, 32'h00000000, 32'h00000001, 1'b0, 0, 1, 0));
        // Instance B: 6-bit address, 16-bit data.
        tbl.push_back(mk_vec(1, 2'b01, 32'h2A,  32'h0000BEEF, 32'h0000BEEF, 1'b0, 1, 0, 0));
        tbl.push_back(mk_vec(1, 2'b00, 32'h2A,  32'h00000000, 32'h0000BEEF, 1'b0, 0, 1, 0));
        tbl.push_back(mk_vec(1, 2'b00, 32'h15,  32'h00000000, 32'h0000B015, 1'b0, 0, 1, 0));
        tbl.push_back(mk_vec(1, 2'b10, 32'h3F,  32'h00001234, 32'h0000FFFF, 1'b0, 0, 0, 1));
`ifdef SPI_SUB_PARITY_EN
        // Corrupted request parity, then the same write with correct parity.
        tbl.push_back(mk_vec(0, 2'b01, 32'h100, 32'h00000001, 32'h00000000, 1'b1, 0, 0, 1));
        tbl.push_back(mk_vec(0, 2'b01, 32'h100, 32'h00000001, 32'h00000001, 1'b0, 1, 0, 0));
        tbl.push_back(mk_vec(0, 2'b00, 32'h100, 32'h00000000, 32'h00000001, 1'b0, 0, 1, 0));
`endif

        // Reset state.
        repeat (3) @(negedge sclk);
        #1;
        check("rst_miso_a", miso_a, 1'b0);
        check("rst_r_en_a", r_en_a, 1'b0);
        check("rst_w_en_a", w_en_a, 1'b0);
        check("rst_err_a",  err_a, 1'b0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_addr_a", addr_a, 10'h0);
        check("rst_data_a", data_o_a, 32'h0);
        check("rst_miso_b", miso_b, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        @(negedge sclk); rst = 1'b0;
        @(negedge sclk);

        // Asynchronous reset while w_en is high drops it without a clock edge.
        req = mk_frame(2'b01, 32'h3, 32'h5A5A5A5A, 10, 32);
        for (int i = 0; i < FW_A; i++) begin
            @(negedge sclk); drive(0, 1'b0, req[FW_A-1-i]);
        end
        @(posedge sclk); #1;
        check("arst_pre_w_en", w_en_a, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst_w_en",  w_en_a, 1'b0);
        check("arst_busy",  busy_a, 1'b0);
        check("arst_addr",  addr_a, 10'h0);
        @(negedge sclk); drive(0, 1'b1, 1'b0);
        @(negedge sclk); rst = 1'b0;
        @(negedge sclk);

        // Table-driven frames.
        for (int k = 0; k < tbl.size(); k++) begin
            do_vec($sformatf("v%0d", k), tbl[k]);
        end

        // Abort during TX: READ 0x3FF (now all ones), cs_n high mid-data.
        req = mk_frame(2'b00, 32'h3FF, 32'h0, 10, 32);
        r_cnt[0] = 0;
        for (int i = 0; i < FW_A; i++) begin
            @(negedge sclk); drive(0, 1'b0, req[FW_A-1-i]);
        end
        @(negedge sclk); drive(0, 1'b0, 1'b0);
        repeat (21) @(posedge sclk);
        @(negedge sclk); drive(0, 1'b1, 1'b0);
        #1 check("txab_data_bit", miso_a, 1'b1);
        @(posedge sclk); #1 check("txab_busy", busy_a, 1'b0);
        @(negedge sclk); #1 check("txab_miso", miso_a, 1'b0);
        check("txab_r_cnt", r_cnt[0], 1);
        @(negedge sclk);

        // Abort during RX after 20 bits of WRITE 0x001 <- 0xAAAAAAAA.
        req = mk_frame(2'b01, 32'h001, 32'hAAAAAAAA, 10, 32);
        w_cnt[0] = 0; e_cnt[0] = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk); drive(0, 1'b0, req[FW_A-1-i]);
        end
        @(posedge sclk); #1 check("rxab_busy_mid", busy_a, 1'b1);
        @(negedge sclk); drive(0, 1'b1, 1'b0);
        @(posedge sclk); #1 check("rxab_busy", busy_a, 1'b0);
        repeat (3) @(posedge sclk);
        #1;
        check("rxab_w_cnt",   w_cnt[0], 0);
        check("rxab_err_cnt", e_cnt[0], 0);
        @(negedge sclk);
        do_vec("rxab_read", mk_vec(0, 2'b00, 32'h001, 32'h0, 32'hC0DE0001, 1'b0, 0, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
